// File: rtl/scan_loader_if.sv
// Byte-stream handshakes between a configuration source and scan_loader.
// master drives in_* and out_ready; slave is the loader side.
interface scan_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/scan_loader.sv
// Streams configuration bytes LSB first into a scan chain, then commits.
// Define SCAN_READBACK_EN to capture the chain output as readback bytes.
module scan_loader #(
  parameter int CHAIN_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cfg_sel,
  scan_loader_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       scan_se,
  output logic       scan_sc,
  output logic [1:0] scan_cfg,
  input  logic       scan_sc_in
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT,
    FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cfg_q, cfg_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          start_q;
  logic          in_rdy;
  logic          rb_busy;

`ifdef SCAN_READBACK_EN
  logic [7:0] cap_q, cap_d;
  logic [7:0] od_q, od_d;
  logic       ov_q, ov_d;

  assign rb_busy       = ov_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
`else
  logic unused_rb;

  assign rb_busy       = 1'b0;
  assign bus.out_valid = 1'b0;
  assign bus.out_data  = '0;
  assign unused_rb     = scan_sc_in ^ bus.out_ready;
`endif

  assign busy         = (state_q != IDLE);
  assign bus.in_ready = in_rdy;

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    byte_d   = byte_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    in_rdy   = 1'b0;
    done     = 1'b0;
    scan_se  = 1'b0;
    scan_sc  = 1'b0;
    scan_cfg = 2'd0;
`ifdef SCAN_READBACK_EN
    cap_d = cap_q;
    od_d  = od_q;
    ov_d  = ov_q;
    if (ov_q && bus.out_ready) ov_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // a held start only launches one load
        if (start && !start_q) begin
          cfg_d   = cfg_sel;
          byte_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_rdy = !rb_busy;
        if (bus.in_valid && in_rdy) begin
          sr_d    = bus.in_data;
          bit_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scan_se = 1'b1;
        scan_sc = sr_q[0];
        sr_d    = {1'b0, sr_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef SCAN_READBACK_EN
        cap_d = {scan_sc_in, cap_q[7:1]};
`endif
        if (bit_q == 3'd7) begin
          byte_d = byte_q + BW'(1);
`ifdef SCAN_READBACK_EN
          od_d = cap_d;
          ov_d = 1'b1;
`endif
          if (byte_q != LAST)
            state_d = LOAD;
          else if (cfg_q != 2'd0)
            state_d = COMMIT;
          else
            state_d = FINISH;
        end
      end
      COMMIT: begin
        scan_cfg = cfg_q;
        state_d  = FINISH;
      end
      FINISH: begin
        if (!rb_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cfg_q   <= 2'd0;
      byte_q  <= '0;
      bit_q   <= 3'd0;
      sr_q    <= 8'd0;
      start_q <= 1'b0;
`ifdef SCAN_READBACK_EN
      cap_q <= 8'd0;
      od_q  <= 8'd0;
      ov_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      start_q <= start;
`ifdef SCAN_READBACK_EN
      cap_q <= cap_d;
      od_q  <= od_d;
      ov_q  <= ov_d;
`endif
    end
  end

endmodule

// File: tb/tb_scan_loader.sv
// Randomized scoreboard bench for scan_loader with a loopback chain model.
// Readback checks are active when SCAN_READBACK_EN is defined.
module tb_scan_loader;
  localparam int CHAIN_LEN = 16;
  localparam int NB = CHAIN_LEN / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic       busy, done, scan_se, scan_sc, scan_sc_in;
  logic [1:0] scan_cfg;

  scan_loader_if bus ();

  scan_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_sel   (cfg_sel),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .scan_se   (scan_se),
    .scan_sc   (scan_sc),
    .scan_cfg  (scan_cfg),
    .scan_sc_in(scan_sc_in)
  );

  always #5 clk = ~clk;

  // grid model: chain[0] holds the oldest bit and feeds scan_sc_in
  logic [CHAIN_LEN-1:0] chain = '0;
  always @(posedge clk)
    if (scan_se) chain <= {scan_sc, chain[CHAIN_LEN-1:1]};
  assign scan_sc_in = chain[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int se_cnt = 0;
  int cm_cnt = 0;

  bit         exp_bits[$];
  int         exp_cfg[$];
  int         exp_lat[$];
  int         exp_nc[$];
  logic [7:0] exp_rb[$];
  logic [7:0] ld[NB];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      se_cnt = 0;
      cm_cnt = 0;
    end else begin
      if (scan_se) begin
        se_cnt++;
        if (exp_bits.size() == 0) chk("bit_extra", 1, 0);
        else chk("scan_sc", scan_sc, exp_bits.pop_front());
      end
      if (scan_cfg != 2'd0) begin
        cm_cnt++;
        chk("commit_se", scan_se, 0);
        if (exp_cfg.size() == 0) chk("cfg_extra", scan_cfg, 0);
        else chk("scan_cfg", scan_cfg, exp_cfg.pop_front());
      end
      if (bus.in_ready && (scan_se || bus.out_valid))
        chk("in_ready_excl", 1, 0);
`ifdef SCAN_READBACK_EN
      if (bus.out_valid && bus.out_ready) begin
        if (exp_rb.size() == 0) chk("rb_extra", bus.out_data, 0);
        else chk("out_data", bus.out_data, exp_rb.pop_front());
      end
`else
      chk("rb_tied", {bus.out_valid, bus.out_data}, 0);
`endif
      if (done) begin
        done_cnt++;
        if (exp_lat.size() == 0) chk("done_extra", 1, 0);
        else begin
          int lat;
          int nc;
          lat = exp_lat.pop_front();
          nc = exp_nc.pop_front();
          if (lat >= 0) chk("latency", cyc - start_cyc, lat);
          chk("se_cycles", se_cnt, CHAIN_LEN);
          chk("commit_cycles", cm_cnt, nc);
        end
        se_cnt = 0;
        cm_cnt = 0;
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 0);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_out_data"}, bus.out_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_scan_se"}, scan_se, 0);
    chk({nm, "_scan_sc"}, scan_sc, 0);
    chk({nm, "_scan_cfg"}, scan_cfg, 0);
  endtask

  task automatic accept_byte(input logic [7:0] b, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (ok) tick();
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk("idle_timeout", idle, 1);
  endtask

  // mode 0: in_valid held, 1: 5-cycle in_valid gap, 2: readback stall
  task automatic run_load(input logic [1:0] cfg, input int mode,
                          input bit hold);
    bit ok;
    int lat;
    logic [CHAIN_LEN-1:0] snap;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++) exp_bits.push_back(ld[k][j]);
    if (cfg != 2'd0) exp_cfg.push_back(int'(cfg));
    lat = (mode == 0) ? 1 + NB * 9 + ((cfg != 2'd0) ? 1 : 0) : -1;
`ifdef SCAN_READBACK_EN
    lat = -1;
    for (int k = 0; k < NB; k++) exp_rb.push_back(chain[8*k +: 8]);
`endif
    exp_lat.push_back(lat);
    exp_nc.push_back((cfg != 2'd0) ? 1 : 0);
    start = 1'b1;
    cfg_sel = cfg;
    start_cyc = cyc;
    bus.in_valid = 1'b1;
    bus.in_data = ld[0];
    tick();
    if (!hold) start = 1'b0;
    cfg_sel = 2'($urandom);
    for (int k = 0; k < NB; k++) begin
      accept_byte(ld[k], ok);
      if (!ok) break;
      if (k + 1 < NB) bus.in_data = ld[k+1];
      else bus.in_valid = 1'b0;
      if (k == 0 && mode == 1) begin
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (!scan_se) break;
        end
        for (int i = 0; i < 5; i++) begin
          chk("gap_scan_se", scan_se, 0);
          if (i < 4) @(negedge clk);
        end
        tick();
      end
`ifdef SCAN_READBACK_EN
      if (k == 0 && mode == 2) begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bus.out_valid) break;
        end
        chk("stall_out_valid", bus.out_valid, 1);
        snap = chain;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_scan_se", scan_se, 0);
        end
        chk("chain_frozen", chain == snap, 1);
        tick();
        bus.out_ready = 1'b1;
      end
`else
      snap = chain;
`endif
    end
    bus.in_valid = 1'b0;
    wait_idle();
    if (hold) begin
      while (cyc - start_cyc < 30) tick();
      start = 1'b0;
    end
    repeat (3) tick();
    chk("bits_left", exp_bits.size(), 0);
    chk("cfg_left", exp_cfg.size(), 0);
    chk("done_left", exp_lat.size(), 0);
    chk("rb_left", exp_rb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int d0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    ld[0] = 8'hA5;
    ld[1] = 8'h3C;
    run_load(2'd2, 0, 1'b0);
    ld[0] = 8'h00;
    ld[1] = 8'h00;
    run_load(2'd0, 0, 1'b0);

    for (int k = 0; k < NB; k++) ld[k] = 8'($urandom);
    run_load(2'd1, 2, 1'b0);
    for (int k = 0; k < NB; k++) ld[k] = 8'($urandom);
    run_load(2'd3, 1, 1'b0);

    for (int k = 0; k < NB; k++) ld[k] = 8'($urandom);
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++) exp_bits.push_back(ld[k][j]);
    start = 1'b1;
    cfg_sel = 2'd1;
    bus.in_valid = 1'b1;
    bus.in_data = ld[0];
    tick();
    start = 1'b0;
    accept_byte(ld[0], ok);
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_zero("rst_mid");
    tick();
    rst = 1'b0;
    exp_bits.delete();
    exp_cfg.delete();
    exp_lat.delete();
    exp_nc.delete();
    exp_rb.delete();
    for (int k = 0; k < NB; k++) ld[k] = 8'($urandom);
    run_load(2'd2, 0, 1'b0);

    d0 = done_cnt;
    for (int k = 0; k < NB; k++) ld[k] = 8'($urandom);
    run_load(2'd0, 0, 1'b1);
    chk("held_start_dones", done_cnt - d0, 1);
    chk("held_start_busy", busy, 0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NB; k++) ld[k] = 8'($urandom);
      run_load(2'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
